program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the instruction-memory load port.
- Takes a byte stream from the debug UART receiver, packs every 4 bytes into one 32-bit instruction, and writes it to instruction memory at consecutive addresses.
- Its outputs connect to the fetch stage's i_instruccion / i_address / i_loading.
- Loading ends on the HALT word or when memory is full; o_done then releases the pipeline for start/step.

Parameters:
- DATA_WIDTH, 32, instruction width; fixed at 32 (four bytes).
- ADDR_STEP, 4, address increment per written word, matching PC_ADDER +4.
- MEM_DEPTH, 64, instruction memory capacity in words.
- HALT_INSTR, 32'hFFFFFFFF, terminating instruction word.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_load_req  in  1  one-cycle request to begin a new program load.
- i_rx_data  in  8  received byte.
- i_rx_done  in  1  one-cycle strobe; i_rx_data valid this cycle.
- o_instruccion  out  DATA_WIDTH  assembled word to memory.
- o_address  out  DATA_WIDTH  byte address of o_instruccion.
- o_wr_en  out  1  one-cycle write strobe; memory writes o_instruccion at o_address.
- o_loading  out  1  high for the whole LOAD state; drives fetch-stage i_loading and holds the PC.
- o_done  out  1  level; high in DONE until next load request or reset.
- o_overflow  out  1  level; high in ERROR.
- o_word_count  out  7  words written in the current load (0..MEM_DEPTH).

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - state=IDLE.
  - All outputs 0, byte counter 0, shift register 0.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE:
  - i_load_req -> LOAD.
  - i_rx_done ignored.
- Entering LOAD: word_count=0, address=0, byte counter=0, o_loading=1 from the next cycle.
- LOAD byte packing:
  - Each i_rx_done shifts the byte in: word <= {word[23:0], i_rx_data}.
  - The first byte received becomes bits [31:24] (big-endian).
  - Byte counter increments 0..3.
- LOAD word write, on the 4th byte (counter==3 with i_rx_done):
  - Next cycle: o_wr_en=1 for exactly 1 cycle.
  - o_instruccion = full word; o_address = ADDR_STEP*word_count (pre-increment).
  - word_count+1; byte counter back to 0.
  - Latency from 4th strobe to o_wr_en is 1 cycle.
  - o_instruccion and o_address hold their values until the next write.
- i_rx_done during the o_wr_en cycle: accepted as byte 0 of the next word. No byte is ever dropped.
- Termination in the o_wr_en cycle:
  - Written word == HALT_INSTR -> DONE on the next edge. The HALT word itself is written.
  - Otherwise, word_count reaches MEM_DEPTH -> ERROR.
  - HALT on the last slot (word MEM_DEPTH-1) -> DONE, not ERROR.
- i_load_req while in LOAD: restarts the load. Counters and address clear, partial word discarded, previously written words not erased.
- DONE:
  - o_loading=0, o_done=1.
  - Further bytes ignored.
  - i_load_req -> LOAD, clears o_done.
- ERROR:
  - o_loading=0, o_overflow=1.
  - Bytes ignored.
  - i_load_req -> LOAD, clears o_overflow.
- Reset mid-LOAD: immediate IDLE; partial word lost; o_loading drops in the cycle after reset is sampled.
- o_wr_en is never asserted outside LOAD, apart from the final write cycle that causes the exit.

Test Plan:
- Reset, load_req, bytes 20,01,00,05 then FF,FF,FF,FF -> o_wr_en at addr 0 with 32'h20010005, then at addr 4 with 32'hFFFFFFFF; o_done=1, o_word_count=2, o_loading=0.
- Back-to-back i_rx_done every cycle for 8 bytes (incl. a strobe in the o_wr_en cycle) -> two writes, 32'h01020304 at 0 and 32'h05060708 at 4; no byte lost.
- 64 non-HALT words -> 64 writes, addresses 0..252; ERROR with o_overflow=1 after the write at 252; no 65th write.
- 63 non-HALT words then HALT -> HALT written at addr 252; o_done=1, o_overflow=0.
- Reset after 2 bytes of a word, then load_req and 4 bytes AA,BB,CC,DD -> single write 32'hAABBCCDD at addr 0.
- In DONE, send 4 bytes -> no o_wr_en; then load_req -> o_done=0, o_loading=1, next word written at addr 0.

Source files
------------

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Writer side of the instruction-memory load port. Bytes arriving from the
// debug UART receiver are packed big-endian into 32-bit instruction words.
// Each completed word is written to instruction memory at consecutive byte
// addresses (0, ADDR_STEP, 2*ADDR_STEP, ...). Loading ends when the HALT word
// is written (DONE) or when memory fills without a HALT (ERROR).
//
// Ports:
//   i_clock        system clock
//   i_reset        synchronous, active-high reset
//   i_load_req     one-cycle request to start (or restart) a program load
//   i_rx_data      received byte
//   i_rx_done      one-cycle strobe, i_rx_data valid this cycle
//   o_instruccion  assembled word presented to instruction memory
//   o_address      byte address of o_instruccion
//   o_wr_en        one-cycle memory write strobe
//   o_loading      high for the whole LOAD state (holds the fetch-stage PC)
//   o_done         level, high in DONE
//   o_overflow     level, high in ERROR
//   o_word_count   words written in the current load (0..MEM_DEPTH)
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_STEP  = 4,
   parameter int                    MEM_DEPTH  = 64,
   parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_load_req,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic [DATA_WIDTH-1:0] o_instruccion,
   output logic [DATA_WIDTH-1:0] o_address,
   output logic                  o_wr_en,
   output logic                  o_loading,
   output logic                  o_done,
   output logic                  o_overflow,
   output logic [6:0]            o_word_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   localparam logic [6:0]            DEPTH_W = 7'(MEM_DEPTH);
   localparam logic [DATA_WIDTH-1:0] STEP_W  = DATA_WIDTH'(ADDR_STEP);

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;
   logic [1:0]              byte_cnt_q, byte_cnt_d;
   logic [6:0]              word_count_q, word_count_d;
   logic                    wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0]   instr_q, instr_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   shifted;

   // Big-endian packing: earlier bytes move toward the MSBs.
   assign shifted = {word_q[DATA_WIDTH-9:0], i_rx_data};

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         word_q       <= '0;
         byte_cnt_q   <= '0;
         word_count_q <= '0;
         wr_en_q      <= 1'b0;
         instr_q      <= '0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         byte_cnt_q   <= byte_cnt_d;
         word_count_q <= word_count_d;
         wr_en_q      <= wr_en_d;
         instr_q      <= instr_d;
         addr_q       <= addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      byte_cnt_d   = byte_cnt_q;
      word_count_d = word_count_q;
      wr_en_d      = 1'b0;
      instr_d      = instr_q;
      addr_d       = addr_q;

      case (state_q)
         S_IDLE: begin
            if (i_load_req) begin
               state_d      = S_LOAD;
               word_d       = '0;
               byte_cnt_d   = '0;
               word_count_d = '0;
               addr_d       = '0;
            end
         end

         S_LOAD: begin
            if (i_load_req) begin
               // Restart: partial word discarded, memory contents untouched.
               state_d      = S_LOAD;
               word_d       = '0;
               byte_cnt_d   = '0;
               word_count_d = '0;
               addr_d       = '0;
            end else if (wr_en_q && (instr_q == HALT_INSTR)) begin
               // HALT has priority so a HALT in the last slot ends in DONE.
               state_d = S_DONE;
            end else if (wr_en_q && (word_count_q == DEPTH_W)) begin
               state_d = S_ERROR;
            end else if (i_rx_done) begin
               // Also taken during the write cycle: that byte starts the
               // next word, so back-to-back strobes never lose data.
               word_d = shifted;
               if (byte_cnt_q == 2'd3) begin
                  wr_en_d      = 1'b1;
                  instr_d      = shifted;
                  addr_d       = STEP_W * {{(DATA_WIDTH-7){1'b0}}, word_count_q};
                  word_count_d = word_count_q + 7'd1;
                  byte_cnt_d   = 2'd0;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end

         S_DONE, S_ERROR: begin
            if (i_load_req) begin
               state_d      = S_LOAD;
               word_d       = '0;
               byte_cnt_d   = '0;
               word_count_d = '0;
               addr_d       = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign o_instruccion = instr_q;
   assign o_address     = addr_q;
   assign o_wr_en       = wr_en_q;
   assign o_loading     = (state_q == S_LOAD);
   assign o_done        = (state_q == S_DONE);
   assign o_overflow    = (state_q == S_ERROR);
   assign o_word_count  = word_count_q;

endmodule
